// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: the PC handshake, the instruction-memory read port and the
// decode-side fetch buffer head, bundled so the fetch unit and its neighbours
// connect through one port.
interface fetch_unit_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) ();

  // PC side
  logic [ADDR_W-1:0] pc_addr;
  logic              redirect;
  logic              pc_hold;

  // instruction memory read port
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  // decode side
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              id_ready;

  // Fetch unit view
  modport master (
    input  pc_addr, redirect, imem_ack, imem_rdata, id_ready,
    output pc_hold, imem_req, imem_addr, if_valid, if_instr, if_pc
  );

  // Surrounding PC / memory / decode view
  modport slave (
    output pc_addr, redirect, imem_ack, imem_rdata, id_ready,
    input  pc_hold, imem_req, imem_addr, if_valid, if_instr, if_pc
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Captures the PC, keeps at most one read outstanding
// to instruction memory, and queues each returned word with its address in a
// DEPTH-entry buffer whose head is presented to decode from registers.
// A redirect flushes the buffer and turns an in-flight read into a discard.
module fetch_unit #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,   // nothing outstanding
    S_WAIT = 2'd1,   // read outstanding, result will be queued
    S_DROP = 2'd2    // read outstanding, result will be discarded
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_q, req_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [DATA_W-1:0] mem_instr_q [DEPTH];
  logic [DATA_W-1:0] mem_instr_d [DEPTH];
  logic [ADDR_W-1:0] mem_pc_q [DEPTH];
  logic [ADDR_W-1:0] mem_pc_d [DEPTH];

  logic              pop;
  logic              push;
  logic              launch;
  logic [CNT_W-1:0]  cnt_after_pop;
  logic [CNT_W-1:0]  cnt_nx;

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == LAST_PTR) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

  // Handshake decode: pop/push, next occupancy and whether a new fetch launches
  always_comb begin
    pop           = if_valid_q & bus.id_ready;
    push          = (state_q == S_WAIT) & bus.imem_ack & ~bus.redirect;
    cnt_after_pop = count_q - CNT_W'(pop);
    if (bus.redirect) begin
      cnt_nx = '0;
    end else begin
      cnt_nx = cnt_after_pop + CNT_W'(push);
    end
    // A pop in this cycle already frees its slot for the launch decision.
    launch = ~bus.redirect & (cnt_nx < DEPTH_C) &
             ((state_q == S_IDLE) | ((state_q == S_WAIT) & bus.imem_ack));
  end

  // Request FSM: next state, request flag and captured request address
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.imem_ack) begin
          // A simultaneous redirect blocks launch, so the word is dropped here.
          state_d = launch ? S_WAIT : S_IDLE;
        end else if (bus.redirect) begin
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        if (bus.imem_ack) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (launch) begin
      req_addr_d = bus.pc_addr;
    end else begin
      req_addr_d = req_addr_q;
    end
    req_d = (state_d != S_IDLE);
  end

  // Fetch buffer storage, pointers, count and registered head
  always_comb begin
    mem_instr_d = mem_instr_q;
    mem_pc_d    = mem_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = cnt_nx;
    if_valid_d  = (cnt_nx != '0);
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    if (bus.redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push) begin
        mem_instr_d[wr_ptr_q] = bus.imem_rdata;
        mem_pc_d[wr_ptr_q]    = req_addr_q;
        wr_ptr_d              = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      // The head slot is being written when the buffer empties this cycle,
      // so forward the returning word straight into the head registers.
      if (push && (cnt_after_pop == '0)) begin
        if_instr_d = bus.imem_rdata;
        if_pc_d    = req_addr_q;
      end else if (cnt_after_pop != '0) begin
        if_instr_d = mem_instr_q[rd_ptr_d];
        if_pc_d    = mem_pc_q[rd_ptr_d];
      end else begin
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
      end
    end
  end

  // State registers; reset abandons any outstanding read immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      req_addr_q <= '0;
      req_q      <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      req_addr_q  <= req_addr_d;
      req_q       <= req_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      mem_instr_q <= mem_instr_d;
      mem_pc_q    <= mem_pc_d;
    end
  end

  assign bus.pc_hold   = ~launch;
  assign bus.imem_req  = req_q;
  assign bus.imem_addr = req_addr_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases plus a randomized phase, all checked
// against a transaction-level model (queue of fetched words, one outstanding
// read record, PC register and a variable-latency memory).
module tb_fetch_unit;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  ent_t          q[$];
  bit            out_v;
  bit            out_drop;
  logic [AW-1:0] out_addr;
  int            lat;
  int            lat_min;
  int            lat_max;
  logic [AW-1:0] pc;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    out_v    = 1'b0;
    out_drop = 1'b0;
    out_addr = '0;
    lat      = 0;
    pc       = '0;
  endtask

  // One cycle: entered just after a rising edge, drives this cycle's inputs,
  // checks the DUT against the model, advances the model, returns after the edge.
  task automatic step(input bit redir, input logic [AW-1:0] tgt, input bit rdy);
    bit   ack, push, pop, launch;
    int   cnt_nx;
    ent_t e;
    ack              = out_v && (lat == 0);
    bus.redirect     = redir;
    bus.pc_addr      = pc;
    bus.id_ready     = rdy;
    bus.imem_ack     = ack;
    bus.imem_rdata   = $urandom;
    #1;
    pop    = (q.size() > 0) && rdy;
    push   = out_v && !out_drop && ack && !redir;
    cnt_nx = redir ? 0 : (q.size() + int'(push) - int'(pop));
    launch = !redir && (cnt_nx < DEPTH) && (!out_v || (!out_drop && ack));
    chk("pc_hold",  64'(bus.pc_hold),  64'(!launch));
    chk("imem_req", 64'(bus.imem_req), 64'(out_v));
    chk("if_valid", 64'(bus.if_valid), 64'(q.size() > 0));
    if (out_v) chk("imem_addr", 64'(bus.imem_addr), 64'(out_addr));
    if (q.size() > 0) begin
      chk("if_pc",    64'(bus.if_pc),    64'(q[0].pc));
      chk("if_instr", 64'(bus.if_instr), 64'(q[0].instr));
    end
    // advance the model to the state after this edge
    if (redir) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.pc    = out_addr;
        e.instr = bus.imem_rdata;
        q.push_back(e);
      end
    end
    if (out_v) begin
      if (ack) begin
        out_v = 1'b0;
      end else begin
        lat--;
        if (redir) out_drop = 1'b1;
      end
    end
    if (launch) begin
      out_v    = 1'b1;
      out_drop = 1'b0;
      out_addr = pc;
      lat      = int'($urandom_range(lat_max, lat_min));
    end
    if (redir)       pc = tgt;
    else if (launch) pc = pc + AW'(4);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    bus.redirect   = 1'b0;
    bus.pc_addr    = '0;
    bus.id_ready   = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    lat_min        = 0;
    lat_max        = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req",  64'(bus.imem_req),  64'd0);
    chk("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_if_valid",  64'(bus.if_valid),  64'd0);
    chk("rst_if_instr",  64'(bus.if_instr),  64'd0);
    chk("rst_if_pc",     64'(bus.if_pc),     64'd0);
    reset = 1'b1;

    // zero-wait memory, decode always ready: one fetch per cycle
    repeat (12) step(1'b0, '0, 1'b1);

    // decode stalled: buffer fills to DEPTH and the PC is held
    repeat (8) step(1'b0, '0, 1'b0);
    chk("full_pc_hold",  64'(bus.pc_hold),  64'd1);
    chk("full_if_valid", 64'(bus.if_valid), 64'd1);
    repeat (6) step(1'b0, '0, 1'b1);

    // three-cycle memory latency
    lat_min = 2;
    lat_max = 2;
    repeat (12) step(1'b0, '0, 1'b1);

    // redirect to 0x40 in the first wait cycle of a read
    for (int i = 0; i < 10 && !(out_v && !out_drop && lat == 2); i++) step(1'b0, '0, 1'b1);
    step(1'b1, AW'(9'h040), 1'b1);
    chk("redir_flush", 64'(bus.if_valid), 64'd0);
    for (int i = 0; i < 20 && !bus.if_valid; i++) step(1'b0, '0, 1'b1);
    chk("redir_valid_seen", 64'(bus.if_valid), 64'd1);
    chk("redir_if_pc",      64'(bus.if_pc),    64'h40);

    // randomized traffic: latency 0..3, random stalls and redirects
    lat_min = 0;
    lat_max = 3;
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(9, 0) == 0), AW'({$urandom_range(127, 0), 2'b00}),
           ($urandom_range(3, 0) != 0));
    end

    // reset while a read is outstanding and the buffer holds an entry
    lat_min = 3;
    lat_max = 3;
    step(1'b1, '0, 1'b0);
    for (int i = 0; i < 30 && !(q.size() == 1 && out_v && !out_drop); i++) step(1'b0, '0, 1'b0);
    chk("pre_rst_req",   64'(bus.imem_req), 64'd1);
    chk("pre_rst_valid", 64'(bus.if_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_imem_req",  64'(bus.imem_req),  64'd0);
    chk("async_rst_imem_addr", 64'(bus.imem_addr), 64'd0);
    chk("async_rst_if_valid",  64'(bus.if_valid),  64'd0);
    chk("async_rst_if_instr",  64'(bus.if_instr),  64'd0);
    chk("async_rst_if_pc",     64'(bus.if_pc),     64'd0);
    model_reset();
    lat_min = 0;
    lat_max = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b0, '0, 1'b1);
    chk("restart_req",  64'(bus.imem_req),  64'd1);
    chk("restart_addr", 64'(bus.imem_addr), 64'd0);
    repeat (8) step(1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
